// File: rtl/mem_bus_ctrl.sv
// CPU memory-stage to single-port data BRAM bridge for byte/half/word loads and stores.
// Latency: a store drives the BRAM one cycle after accept; a load result lands READ_LATENCY+1 clocks after accept.
// Backpressure: busy_out is high while an access is pending or running; a dispatch seen while not idle is dropped.
module mem_bus_ctrl #(
   parameter int ADDR_WIDTH   = 14,
   parameter int READ_LATENCY = 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [31:0]           addr_in,
   input  logic [1:0]            mem_width_in,
   input  logic                  dispatch_read_in,
   input  logic                  dispatch_write_in,
   input  logic [31:0]           write_data_in,
   output logic                  busy_out,
   output logic [31:0]           read_data_out,
   output logic                  err_out,
   output logic [ADDR_WIDTH-1:0] bram_addr_out,
   output logic [3:0]            bram_we_out,
   output logic [31:0]           bram_din_out,
   input  logic [31:0]           bram_dout_in
);

   localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      W_BYTE  = 2'd0,
      W_WORD  = 2'd1,
      W_DWORD = 2'd2,
      W_BAD   = 2'd3
   } width_e;

   // Request context that must survive until a load completes.
   typedef struct packed {
      logic [1:0] lane;
      width_e     width;
   } req_t;

   state_e            state;
   req_t              req_q;
   logic [CNT_W-1:0]  lat_cnt;

   width_e            req_width;
   logic              any_dispatch;
   logic              both_dispatch;
   logic              req_bad;
   logic [3:0]        we_mask;
   logic [31:0]       din_lanes;
   logic [31:0]       rd_shift;
   logic [31:0]       rd_lane;

   // Upper address bits lie outside the BRAM window and are deliberately ignored.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^addr_in[31:ADDR_WIDTH+2];

   assign req_width     = width_e'(mem_width_in);
   assign any_dispatch  = dispatch_read_in | dispatch_write_in;
   assign both_dispatch = dispatch_read_in & dispatch_write_in;

   // Busy covers the dispatch cycle itself so the CPU stalls without waiting a clock.
   assign busy_out = ~rst_in & ((state != IDLE) | any_dispatch);

   // Decode the incoming request: legality, byte enables and lane-replicated store data.
   always_comb begin
      req_bad   = 1'b0;
      we_mask   = 4'b0000;
      din_lanes = write_data_in;
      case (req_width)
         W_BYTE: begin
            we_mask   = 4'b0001 << addr_in[1:0];
            din_lanes = {4{write_data_in[7:0]}};
         end
         W_WORD: begin
            req_bad   = addr_in[0];
            we_mask   = addr_in[1] ? 4'b1100 : 4'b0011;
            din_lanes = {2{write_data_in[15:0]}};
         end
         W_DWORD: begin
            req_bad   = (addr_in[1:0] != 2'b00);
            we_mask   = 4'b1111;
            din_lanes = write_data_in;
         end
         default: begin
            req_bad   = 1'b1;
            we_mask   = 4'b0000;
            din_lanes = write_data_in;
         end
      endcase
   end

   // Pull the addressed byte or half out of the BRAM word and zero-extend it.
   always_comb begin
      rd_shift = bram_dout_in >> {req_q.lane, 3'b000};
      rd_lane  = bram_dout_in;
      case (req_q.width)
         W_BYTE:  rd_lane = {24'd0, rd_shift[7:0]};
         W_WORD:  rd_lane = {16'd0, rd_shift[15:0]};
         default: rd_lane = bram_dout_in;
      endcase
   end

   // Control FSM with registered BRAM strobes, error pulse and load result.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= IDLE;
         req_q         <= '{lane: 2'b00, width: W_BYTE};
         lat_cnt       <= '0;
         bram_addr_out <= '0;
         bram_we_out   <= 4'b0000;
         bram_din_out  <= '0;
         read_data_out <= '0;
         err_out       <= 1'b0;
      end else begin
         err_out <= 1'b0;
         case (state)
            IDLE: begin
               if (any_dispatch) begin
                  // Simultaneous read+write resolves to the write but is still flagged.
                  err_out <= req_bad | both_dispatch;
                  if (!req_bad) begin
                     req_q         <= '{lane: addr_in[1:0], width: req_width};
                     bram_addr_out <= addr_in[ADDR_WIDTH+1:2];
                     if (dispatch_write_in) begin
                        state        <= WRITE;
                        bram_we_out  <= we_mask;
                        bram_din_out <= din_lanes;
                     end else begin
                        state   <= READ;
                        lat_cnt <= '0;
                     end
                  end
               end
            end
            READ: begin
               if (lat_cnt == CNT_W'(READ_LATENCY)) begin
                  read_data_out <= rd_lane;
                  state         <= IDLE;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            WRITE: begin
               bram_we_out  <= 4'b0000;
               bram_din_out <= '0;
               state        <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
